// File: rtl/freq_div_prog.sv
// Programmable integer clock divider: divides clk_10M by a runtime-loadable N >= 2,
// producing a registered square wave (ceil(N/2) low, floor(N/2) high) and a wrap tick.
module freq_div_prog #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = 20
) (
  input  logic             clk_10M,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_pend,
  output logic             err
);

  localparam logic [CNT_W-1:0] DivDef = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DivMin = CNT_W'(2);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_n_q, div_n_d;
  logic [CNT_W-1:0] div_p_q, div_p_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             load_ok;
  logic             load_bad;
  logic [CNT_W-1:0] low_len;

  always_comb begin
    wrap     = en && (cnt_q == (div_n_q - One));
    load_ok  = en && div_load && (div_val >= DivMin);
    load_bad = en && div_load && (div_val < DivMin);

    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + One;
    end

    // A wrap consumes the value that was pending before this cycle's load.
    div_n_d = (wrap && pend_q) ? div_p_q : div_n_q;
    div_p_d = load_ok ? div_val : div_p_q;
    pend_d  = load_ok ? 1'b1 : (wrap ? 1'b0 : pend_q);

    // Output flop is computed from the next count and next divisor.
    low_len = div_n_d - (div_n_d >> 1);
    clk_d   = (cnt_d >= low_len);
    tick_d  = wrap;
    err_d   = load_bad;
  end

  always_ff @(posedge clk_10M) begin
    if (reset) begin
      cnt_q   <= '0;
      div_n_q <= DivDef;
      div_p_q <= DivDef;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_n_q <= div_n_d;
      div_p_q <= div_p_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign div_cur   = div_n_q;
  assign load_pend = pend_q;
  assign err       = err_q;

endmodule
